// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request feeding a 2-entry
// instruction FIFO toward decode. Define FETCH_PERF_CNT_EN to add a memory-wait cycle counter.
module instr_fetch_stage #(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NBITS-1:0] i_PC,
  input  logic             i_flush,
  input  logic             i_stall,
  output logic             o_imem_req,
  output logic [NBITS-1:0] o_imem_addr,
  input  logic             i_imem_ack,
  input  logic [NBITS-1:0] i_imem_rdata,
  output logic             o_PC_Write,
  output logic             o_valid,
  output logic [NBITS-1:0] o_instr,
  output logic [NBITS-1:0] o_PC_4,
  output logic [31:0]      o_wait_cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [NBITS-1:0] instr_q [2];
  logic [NBITS-1:0] instr_d [2];
  logic [NBITS-1:0] pc4_q   [2];
  logic [NBITS-1:0] pc4_d   [2];

  logic       push;
  logic       pop;
  logic [2:0] proj_count;
  logic       can_issue;

  // A new request is only issued if its response is guaranteed a FIFO slot.
  always_comb begin
    push       = (state_q == BUSY) && i_imem_ack && !i_flush;
    pop        = (count_q != 2'd0) && !i_stall && !i_flush;
    proj_count = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};
    can_issue  = !i_flush && (proj_count <= 3'd1);
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (can_issue) begin
          state_d = BUSY;
          addr_d  = i_PC;
        end
      end
      BUSY: begin
        if (i_flush) begin
          state_d = i_imem_ack ? IDLE : DRAIN;
        end else if (i_imem_ack) begin
          if (can_issue) begin
            addr_d = i_PC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (i_imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    if (i_flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = i_imem_rdata;
        pc4_d[wr_ptr_q]   = addr_q + NBITS'(4);
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = proj_count[1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      // NOTE: the FIFO storage is reset because the head entry drives
      // o_instr/o_PC_4 directly and those must read zero out of reset.
      instr_q  <= '{default: '0};
      pc4_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
    end
  end

  assign o_imem_req  = (state_q == BUSY) || (state_q == DRAIN);
  assign o_imem_addr = addr_q;
  assign o_PC_Write  = !i_reset && (push || i_flush);
  assign o_valid     = (count_q != 2'd0);
  assign o_instr     = instr_q[rd_ptr_q];
  assign o_PC_4      = pc4_q[rd_ptr_q];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (o_imem_req && !i_imem_ack && (wait_q != 32'hFFFF_FFFF)) begin
      wait_d = wait_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wait_q <= 32'd0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign o_wait_cycles = wait_q;
`else
  assign o_wait_cycles = 32'd0;
`endif

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter NBITS, default 32: width of PC, address and instruction words.
REQ-002 i_clk  in  1  single clock; all state updates on posedge i_clk.
REQ-003 i_reset  in  1  synchronous, active-high reset, sampled on posedge i_clk.
REQ-004 i_PC  in  NBITS  current PC from the PC register; address of the next fetch.
REQ-005 i_flush  in  1  redirect (branch/jump taken); discards all fetched and in-flight work.
REQ-006 i_stall  in  1  decode cannot accept this cycle.
REQ-007 o_imem_req  out  1  instruction-memory request, level, held until acknowledged.
REQ-008 o_imem_addr  out  NBITS  request address, stable while o_imem_req is high.
REQ-009 i_imem_ack  in  1  memory completes the pending request this cycle.
REQ-010 i_imem_rdata  in  NBITS  instruction word, valid only with i_imem_ack.
REQ-011 o_PC_Write  out  1  write enable to the PC register.
REQ-012 o_valid  out  1  o_instr/o_PC_4 hold a valid instruction for decode.
REQ-013 o_instr  out  NBITS  instruction at FIFO head.
REQ-014 o_PC_4  out  NBITS  fetch address + 4 of FIFO head, modulo 2^NBITS.
REQ-015 o_wait_cycles  out  32  memory-wait cycle count (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, BUSY (request outstanding) and DRAIN (flushed request outstanding, response discarded).
REQ-017 IDLE->BUSY SHALL occur when !i_flush and projected occupancy (count + push - pop this cycle) <= 1; i_PC is latched into the address register on that edge.
REQ-018 o_imem_req SHALL be high in BUSY and DRAIN only; o_imem_addr SHALL equal the latched address.
REQ-019 Ack in BUSY SHALL push {rdata, addr+4} into a 2-entry FIFO and return to IDLE, or stay in BUSY with a new latched i_PC if REQ-017 permits in the same cycle.
REQ-020 Ack in DRAIN SHALL discard rdata and go to IDLE; nothing is pushed.
REQ-021 o_PC_Write SHALL be high for exactly the cycles with (BUSY and i_imem_ack and !i_flush) or i_flush.
REQ-022 Pop SHALL occur when o_valid and !i_stall; push and pop in the same cycle leave count unchanged.
REQ-023 o_valid SHALL equal (count != 0); o_instr/o_PC_4 SHALL show the oldest entry, combinationally from FIFO storage.
REQ-024 Minimum latency: ack at cycle N -> o_valid high from cycle N+1.
REQ-025 i_flush SHALL have priority: count becomes 0 on that edge; BUSY->DRAIN (or BUSY->IDLE if ack the same cycle); DRAIN stays DRAIN; push and pop are suppressed.
REQ-026 Count SHALL never exceed 2; with count 2 and no pop, no request is issued.
REQ-027 A write pointer wrap from 1 to 0 SHALL be seamless; pointers are 1 bit each.

Reset
REQ-028 On i_reset: state IDLE, count 0, pointers 0, address register 0, o_wait_cycles 0.
REQ-029 After reset: o_valid 0, o_imem_req 0, o_PC_Write 0, o_instr 0, o_PC_4 0.
REQ-030 Reset SHALL override flush, ack and stall in the same cycle; an ack arriving after reset is ignored (state IDLE).

Configuration
REQ-031 Macro FETCH_PERF_CNT_EN defined: o_wait_cycles SHALL increment by 1 each cycle with o_imem_req high and i_imem_ack low, saturating at 0xFFFFFFFF.
REQ-032 Macro FETCH_PERF_CNT_EN undefined: no counter register; o_wait_cycles SHALL be tied to 0.

Verification
REQ-033 Reset, then i_PC=0x00000000, ack 1 cycle after req with rdata=0x20080005 -> o_imem_addr=0x0, o_PC_Write pulse 1 cycle, next cycle o_valid=1, o_instr=0x20080005, o_PC_4=0x4.
REQ-034 i_stall held high, acks for 0x0/0x4/0x8 available -> count reaches 2, no third req until stall drops; pop order 0x4 then 0x8 on o_PC_4.
REQ-035 Flush asserted while BUSY at 0x10, ack 3 cycles later -> DRAIN, o_valid=0 next cycle, rdata discarded, o_PC_Write high only in flush cycle, next req uses new i_PC=0x40.
REQ-036 Flush and ack in same cycle with count 1 -> count 0, state IDLE, no push, o_PC_Write=1 once.
REQ-037 i_PC=0xFFFFFFFC fetched -> o_PC_4=0x00000000.
REQ-038 With FETCH_PERF_CNT_EN, 4 unacked req cycles -> o_wait_cycles=4; reset mid-wait -> 0 and o_imem_req=0 next cycle; without macro -> always 0.
